// File: rtl/bayer_to_rgb.sv
// bayer_to_rgb: 12-bit Bayer (G1 R / B G2) to half-resolution 12-bit RGB.
// The even row (G1,R pairs) is parked in a line buffer. Each odd-row quad
// is then completed on the fly: B is held locally, and G2 arrives last.
// Optional build macro BAYER_TO_RGB_EOF_EN adds a row counter and an o_eof
// pulse on the last pixel of each frame.
module bayer_to_rgb #(
  parameter int IMG_WIDTH  = 1280,
  parameter int IMG_HEIGHT = 960
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [11:0] i_raw,
  input  logic        i_valid,
  input  logic        i_sof,
  output logic [11:0] o_red,
  output logic [11:0] o_green,
  output logic [11:0] o_blue,
`ifdef BAYER_TO_RGB_EOF_EN
  output logic        o_eof,
`endif
  output logic        o_valid
);

  localparam int CW    = (IMG_WIDTH > 2) ? $clog2(IMG_WIDTH) : 1;
  localparam int DEPTH = IMG_WIDTH / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

  // Reject geometries that cannot tile into 2x2 quads.
  generate
    if (IMG_WIDTH < 2 || (IMG_WIDTH % 2) != 0) begin : g_bad_width
      $error("bayer_to_rgb: IMG_WIDTH must be even and >= 2");
    end
    if (IMG_HEIGHT < 2 || (IMG_HEIGHT % 2) != 0) begin : g_bad_height
      $error("bayer_to_rgb: IMG_HEIGHT must be even and >= 2");
    end
  endgenerate

  logic [CW-1:0] col_q, col_d, eff_col;
  logic          odd_q, odd_d, eff_odd;
  logic [11:0]   g1_q, g1_d, b_q, b_d;
  logic [11:0]   red_q, red_d, grn_q, grn_d, blu_q, blu_d;
  logic          vld_q, vld_d;
  logic          col_last, wr_en, rd_en;
  logic [AW-1:0] addr;
  logic [23:0]   rd_q;
  logic [23:0]   mem [DEPTH];

  // A sof sample is forced to (row 0, col 0), abandoning any partial line.
  assign eff_col  = i_sof ? '0 : col_q;
  assign eff_odd  = i_sof ? 1'b0 : odd_q;
  assign col_last = (eff_col == COL_LAST);
  assign addr     = AW'(eff_col >> 1);
  assign wr_en    = i_valid && !eff_odd &&  eff_col[0];
  assign rd_en    = i_valid &&  eff_odd && !eff_col[0];

  // Next-state: position counters, hold registers and the output pixel.
  always_comb begin
    col_d = col_q;
    odd_d = odd_q;
    g1_d  = g1_q;
    b_d   = b_q;
    red_d = red_q;
    grn_d = grn_q;
    blu_d = blu_q;
    vld_d = 1'b0;
    if (i_valid) begin
      col_d = col_last ? '0 : eff_col + 1'b1;
      odd_d = col_last ? ~eff_odd : eff_odd;
      if (!eff_odd && !eff_col[0]) g1_d = i_raw;
      if ( eff_odd && !eff_col[0]) b_d  = i_raw;
      if ( eff_odd &&  eff_col[0]) begin
        // Quad complete: i_raw is G2, line buffer read data holds {G1,R}.
        vld_d = 1'b1;
        red_d = rd_q[11:0];
        blu_d = b_q;
        grn_d = 12'((13'(rd_q[23:12]) + 13'(i_raw)) >> 1);
      end
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      col_q <= '0;
      odd_q <= 1'b0;
      g1_q  <= '0;
      b_q   <= '0;
      red_q <= '0;
      grn_q <= '0;
      blu_q <= '0;
      vld_q <= 1'b0;
    end else begin
      col_q <= col_d;
      odd_q <= odd_d;
      g1_q  <= g1_d;
      b_q   <= b_d;
      red_q <= red_d;
      grn_q <= grn_d;
      blu_q <= blu_d;
      vld_q <= vld_d;
    end
  end

  // Line buffer: written on even rows, read one sample ahead on odd rows.
  // Read data stays put across input gaps until the next read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[addr] <= {g1_q, i_raw};
    if (rd_en) rd_q <= mem[addr];
  end

  assign o_red   = red_q;
  assign o_green = grn_q;
  assign o_blue  = blu_q;
  assign o_valid = vld_q;

`ifdef BAYER_TO_RGB_EOF_EN
  localparam int RW = (IMG_HEIGHT > 2) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [RW-1:0] row_q, row_d, eff_row;
  logic          eof_q, eof_d;

  assign eff_row = i_sof ? '0 : row_q;

  // Frame row tracking; eof marks the pixel completing the last quad.
  always_comb begin
    row_d = row_q;
    eof_d = 1'b0;
    if (i_valid) begin
      if (col_last) row_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
      eof_d = eff_odd && col_last && (eff_row == ROW_LAST);
    end
  end

  // Row counter and eof register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row_q <= '0;
      eof_q <= 1'b0;
    end else begin
      row_q <= row_d;
      eof_q <= eof_d;
    end
  end

  assign o_eof = eof_q;
`endif

endmodule

// File: tb/tb_bayer_to_rgb.sv
// Bench for bayer_to_rgb at IMG_WIDTH=4, IMG_HEIGHT=2. A frame-position
// model stores raw samples in a 2D array and forms each quad's RGB directly.
module tb_bayer_to_rgb;
  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld = 1'b0;
  logic        sof = 1'b0;
  logic [11:0] raw = '0;
  logic [11:0] r_o, g_o, b_o;
  logic        v_o;
`ifdef BAYER_TO_RGB_EOF_EN
  logic        e_o;
`endif

  bayer_to_rgb #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_raw   (raw),
    .i_valid (vld),
    .i_sof   (sof),
    .o_red   (r_o),
    .o_green (g_o),
    .o_blue  (b_o),
`ifdef BAYER_TO_RGB_EOF_EN
    .o_eof   (e_o),
`endif
    .o_valid (v_o)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nfail = 0;
  int eof_cnt = 0;

  // Reference model state: position in frame and last expected pixel.
  int          mr = 0;
  int          mc = 0;
  logic [11:0] fr [H][W];
  logic [11:0] er = '0, eg = '0, eb = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      $error("check %s", tag);
    end
  endtask

  task automatic model_reset();
    mr = 0; mc = 0; er = '0; eg = '0; eb = '0;
  endtask

  // Drive one cycle, advance the model, check outputs #1 after the edge.
  task automatic step(input bit v, input bit s, input logic [11:0] d);
    logic ev, ee;
    ev = 1'b0;
    ee = 1'b0;
    vld = v;
    sof = s & v;
    raw = d;
    if (v) begin
      if (s) begin mr = 0; mc = 0; end
      fr[mr][mc] = d;
      if ((mr % 2) == 1 && (mc % 2) == 1) begin
        ev = 1'b1;
        er = fr[mr-1][mc];
        eb = fr[mr][mc-1];
        eg = 12'((13'(fr[mr-1][mc-1]) + 13'(d)) >> 1);
        ee = (mr == H - 1) && (mc == W - 1);
      end
      mc++;
      if (mc == W) begin mc = 0; mr = (mr + 1) % H; end
    end
    @(posedge clk);
    #1;
    vld = 1'b0;
    sof = 1'b0;
    chk("valid", 32'(v_o), 32'(ev));
    chk("red",   32'(r_o), 32'(er));
    chk("green", 32'(g_o), 32'(eg));
    chk("blue",  32'(b_o), 32'(eb));
`ifdef BAYER_TO_RGB_EOF_EN
    chk("eof",   32'(e_o), 32'(ee));
    if (e_o) eof_cnt++;
`endif
  endtask

  logic [11:0] basic [8];
  logic [11:0] fq [8];

  initial begin
    basic = '{12'h100, 12'h200, 12'h110, 12'h210, 12'h300, 12'h120, 12'h310, 12'h130};

    // Reset state
    #3;
    chk("rst_valid", 32'(v_o), 32'h0);
    chk("rst_red",   32'(r_o), 32'h0);
    chk("rst_green", 32'(g_o), 32'h0);
    chk("rst_blue",  32'(b_o), 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Basic quad, valid every cycle
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, basic[i]);
    step(1'b0, 1'b0, 12'h0);
    chk("basic_r2", 32'(r_o), 32'h210);
    chk("basic_g2", 32'(g_o), 32'h120);
    chk("basic_b2", 32'(b_o), 32'h310);

    // Green truncation and saturation
    fq = '{12'h001, 12'h0AA, 12'hFFF, 12'h0BB, 12'h0CC, 12'h002, 12'h0DD, 12'hFFF};
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, fq[i]);
      if (i == 5) chk("trunc_green", 32'(g_o), 32'h001);
      if (i == 7) chk("sat_green",   32'(g_o), 32'hFFF);
    end

    // Valid gaps: two idle cycles after every sample
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, basic[i]);
      step(1'b0, 1'b0, 12'h0);
      step(1'b0, 1'b0, 12'h0);
    end

    // Mid-line sof: partial row abandoned, then a full frame
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 12'(32'h700 + i));
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, basic[i]);

    // Mid odd-row sof: new frame restarts cleanly
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 12'($urandom));
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, basic[i]);

    // Random frames with random gaps; sof sometimes omitted on frame start
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 8; i++) begin
        step(1'b1, (i == 0) && ($urandom_range(0, 3) != 0), 12'($urandom));
        while ($urandom_range(0, 2) == 0) step(1'b0, 1'($urandom), 12'($urandom));
      end
    end

    // Async reset between row1 col0 and col1
    for (int i = 0; i < 8; i++) step(1'b1, i == 0, basic[i]);
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 12'($urandom));
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(v_o), 32'h0);
    chk("arst_red",   32'(r_o), 32'h0);
    chk("arst_green", 32'(g_o), 32'h0);
    chk("arst_blue",  32'(b_o), 32'h0);
    model_reset();
    #2 rst_n = 1'b1;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, basic[i]);
    step(1'b0, 1'b0, 12'h0);
    chk("post_rst_red", 32'(r_o), 32'h210);
    chk("post_rst_grn", 32'(g_o), 32'h120);
    chk("post_rst_blu", 32'(b_o), 32'h310);

`ifdef BAYER_TO_RGB_EOF_EN
    // Two back-to-back frames give exactly two eof pulses
    eof_cnt = 0;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) step(1'b1, (f == 0) && (i == 0), basic[i]);
    chk("eof_count", 32'(eof_cnt), 32'd2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
